bht_spec: RTL and testbench
===========================

Name: bht_spec

Overview:
Speculative branch history tracker: a per-index global/local history table updated with the predicted direction at predict time, then confirmed or repaired at in-order resolve. An internal checkpoint FIFO saves each prediction's prior history. On mispredict, a repair FSM rolls back all younger wrong-path updates and writes the corrected history. Sits between the fetch-stage index hash and the PHT: out indexes the PHT; resolve comes from execute.

Parameters:
IWIDTH, 6, table index width; table has 2**IWIDTH entries
HWIDTH, 6, history bits per entry (>=2)
DEPTH, 8, max in-flight predictions; power of two, >=2

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
en  in  1  global advance enable; 0 freezes all state
pred_valid  in  1  predict request
pred_index  in  IWIDTH  hashed branch index
pred_guess  in  1  predicted direction, shifted in speculatively
pred_ready  out  1  predict accepted this cycle when high
pred_hist  out  HWIDTH  tb[pred_index] before this cycle's update (combinational)
resolve_valid  in  1  oldest in-flight branch resolved
resolve_taken  in  1  actual direction
resolve_mispredict  in  1  actual != guess
resolve_ready  out  1  resolve accepted when high
busy  out  1  repair in progress
inflight  out  $clog2(DEPTH)+1  checkpoint count

Behaviour:
- Clocking: one clock, clk; reset is synchronous and active-high. Reset (priority over en): all table entries 0, FIFO empty, state IDLE. After reset: pred_ready=1, resolve_ready=0, busy=0, inflight=0.
- Table reads are combinational from registered state. Writes take effect at the next edge. No same-cycle bypass.
- pred_fire = en & pred_valid & pred_ready.
- pred_ready = IDLE & !full & !(resolve_valid & resolve_mispredict).
- On pred_fire: push {pred_index, tb[pred_index]}; tb[pred_index] <= {tb[pred_index][HWIDTH-2:0], pred_guess}.
- res_fire = en & resolve_valid & resolve_ready.
- resolve_ready = IDLE & !empty.
- Correct resolve: pop the head, no table write. This may coincide with pred_fire; push and pop both happen, inflight is unchanged. This also holds when full: pred_ready=0 that cycle, so no push.
- Mispredict resolve: latch resolve_taken, set rp = tail-1, go to REPAIR. No push that cycle.
- REPAIR (en-gated, one write per cycle, busy=1):
  - While rp != head: tb[ckpt[rp].index] <= ckpt[rp].hist; rp--.
  - When rp == head: tb[ckpt[head].index] <= {ckpt[head].hist[HWIDTH-2:0], taken_latched}; empty the FIFO; go to IDLE.
  - Repair lasts exactly inflight-at-mispredict cycles, minimum 1.
  - Youngest-to-oldest order makes repeated indices end at the oldest saved value.
- Pointer wrap: head, tail and rp are log2(DEPTH) bits and wrap modulo DEPTH. full/empty are derived from the count.
- en=0: no state change; ready outputs still computed; fires impossible.
- Reset mid-REPAIR: abort, full reset values. A partial repair is not preserved.
- resolve_valid while empty or in REPAIR: ignored (resolve_ready=0). The source must hold the request.

Decomposition:
- Package bht_pkg:
  - typedef enum {IDLE, REPAIR} bht_state_t
  - parametrised ckpt_t {index, hist} via a struct-generating macro or per-module typedef
  - localparam helpers for pointer width.
- Sub-module bht_ckpt_fifo: DEPTH-entry circular buffer with push/pop/flush, random read at rp, count/full/empty.
- bht_spec holds the table, the FSM and the ready logic.

Test Plan:
- Reset, then idle -> pred_ready=1, resolve_ready=0, busy=0, inflight=0, pred_hist=0 for index 0..63.
- Predict idx3 guess 1 on two consecutive cycles -> pred_hist 000000 then 000001; next cycle pred_hist(idx3)=000011. Two correct resolves -> tb[3] stays 000011, inflight 2->1->0.
- Predict idx5 g0, idx7 g1, idx5 g1, then mispredict resolve taken=1:
  - busy high for exactly 3 cycles; pred_ready=0 throughout.
  - After repair: tb[7]=000000, tb[5]=000001, inflight=0.
- 8 predicts without resolve -> pred_ready drops after the 8th, inflight=8. Correct resolve pops one; pred_ready=1 the next cycle. Simultaneous pred+correct resolve at inflight=4 -> inflight stays 4, pointers wrap correctly.
- en=0 for 5 cycles with pred_valid and resolve_valid asserted -> table, inflight and state unchanged. en=0 during REPAIR stretches busy by the same number of cycles.
- Reset asserted in the 2nd REPAIR cycle -> next cycle all entries 0, IDLE, inflight 0, busy 0.

Source files
------------

// File: rtl/bht_pkg.sv
// Shared types and sizing helpers for the speculative branch history tracker.
package bht_pkg;
  typedef enum logic {IDLE = 1'b0, REPAIR = 1'b1} bht_state_t;

  localparam int IWIDTH_DEF = 6;
  localparam int HWIDTH_DEF = 6;
  localparam int DEPTH_DEF  = 8;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/bht_if.sv
// Predict/resolve bus between fetch hash, execute and the history tracker.
interface bht_if import bht_pkg::*; #(
  parameter int IWIDTH = IWIDTH_DEF,
  parameter int HWIDTH = HWIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF
);
  logic                     pred_valid;
  logic [IWIDTH-1:0]        pred_index;
  logic                     pred_guess;
  logic                     pred_ready;
  logic [HWIDTH-1:0]        pred_hist;
  logic                     resolve_valid;
  logic                     resolve_taken;
  logic                     resolve_mispredict;
  logic                     resolve_ready;
  logic                     busy;
  logic [cnt_w(DEPTH)-1:0]  inflight;

  modport master (
    output pred_valid, pred_index, pred_guess,
           resolve_valid, resolve_taken, resolve_mispredict,
    input  pred_ready, pred_hist, resolve_ready, busy, inflight
  );

  modport slave (
    input  pred_valid, pred_index, pred_guess,
           resolve_valid, resolve_taken, resolve_mispredict,
    output pred_ready, pred_hist, resolve_ready, busy, inflight
  );
endinterface

// File: rtl/bht_ckpt_fifo.sv
// Circular checkpoint buffer: in-order push/pop, flush, random read at rp.
module bht_ckpt_fifo import bht_pkg::*; #(
  parameter int IWIDTH = IWIDTH_DEF,
  parameter int HWIDTH = HWIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int PW    = ptr_w(DEPTH),
  localparam int CW    = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [IWIDTH-1:0] push_index,
  input  logic [HWIDTH-1:0] push_hist,
  input  logic [PW-1:0]     rp,
  output logic [IWIDTH-1:0] rd_index,
  output logic [HWIDTH-1:0] rd_hist,
  output logic [PW-1:0]     head,
  output logic [PW-1:0]     tail,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);
  typedef struct packed {
    logic [IWIDTH-1:0] index;
    logic [HWIDTH-1:0] hist;
  } ckpt_t;

  ckpt_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= '{index: push_index, hist: push_hist};
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  assign rd_index = mem[rp].index;
  assign rd_hist  = mem[rp].hist;
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
endmodule

// File: rtl/bht_spec.sv
// Speculative history table: shift predicted direction in at predict time,
// roll back wrong-path updates youngest-first on a mispredict.
module bht_spec import bht_pkg::*; #(
  parameter int IWIDTH = IWIDTH_DEF,
  parameter int HWIDTH = HWIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  bht_if.slave bus
);
  localparam int PW      = ptr_w(DEPTH);
  localparam int CW      = cnt_w(DEPTH);
  localparam int ENTRIES = 2 ** IWIDTH;

  logic [HWIDTH-1:0] tbl [ENTRIES];
  bht_state_t        state, state_d;
  logic [PW-1:0]     rp, rp_d, head, tail;
  logic              taken_q, taken_d;
  logic [IWIDTH-1:0] rd_index, wa;
  logic [HWIDTH-1:0] rd_hist, wd;
  logic [CW-1:0]     count;
  logic              full, empty;
  logic              pred_fire, res_fire, pop, flush, we;

  assign bus.pred_ready    = (state == IDLE) && !full &&
                             !(bus.resolve_valid && bus.resolve_mispredict);
  assign bus.resolve_ready = (state == IDLE) && !empty;
  assign bus.pred_hist     = tbl[bus.pred_index];
  assign bus.busy          = (state == REPAIR);
  assign bus.inflight      = count;

  assign pred_fire = en && bus.pred_valid && bus.pred_ready;
  assign res_fire  = en && bus.resolve_valid && bus.resolve_ready;
  assign pop       = res_fire && !bus.resolve_mispredict;

  bht_ckpt_fifo #(.IWIDTH(IWIDTH), .HWIDTH(HWIDTH), .DEPTH(DEPTH)) u_ckpt (
    .clk(clk), .reset(reset), .push(pred_fire), .pop(pop), .flush(flush),
    .push_index(bus.pred_index), .push_hist(bus.pred_hist), .rp(rp),
    .rd_index(rd_index), .rd_hist(rd_hist), .head(head), .tail(tail),
    .count(count), .full(full), .empty(empty)
  );

  always_comb begin
    state_d = state;
    rp_d    = rp;
    taken_d = taken_q;
    flush   = 1'b0;
    we      = 1'b0;
    wa      = bus.pred_index;
    wd      = {bus.pred_hist[HWIDTH-2:0], bus.pred_guess};
    case (state)
      IDLE: begin
        we = pred_fire;
        if (res_fire && bus.resolve_mispredict) begin
          state_d = REPAIR;
          rp_d    = tail - PW'(1);
          taken_d = bus.resolve_taken;
        end
      end
      REPAIR: if (en) begin
        // Restoring youngest-first leaves repeated indices at the oldest saved value.
        we = 1'b1;
        wa = rd_index;
        if (rp != head) begin
          wd   = rd_hist;
          rp_d = rp - PW'(1);
        end else begin
          wd      = {rd_hist[HWIDTH-2:0], taken_q};
          flush   = 1'b1;
          state_d = IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rp      <= '0;
      taken_q <= 1'b0;
    end else begin
      state   <= state_d;
      rp      <= rp_d;
      taken_q <= taken_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= '0;
    end else if (we) begin
      tbl[wa] <= wd;
    end
  end
endmodule

// File: tb/tb_bht_spec.sv
// Bench for bht_spec: scenario tasks plus a predict scoreboard on pred_hist.
module tb_bht_spec;
  localparam int IW = 6;
  localparam int HW = 6;
  localparam int D  = 8;
  localparam int N  = 64;

  logic clk = 1'b0;
  logic reset;
  logic en;
  always #5 clk = ~clk;

  bht_if #(.IWIDTH(IW), .HWIDTH(HW), .DEPTH(D)) bus();
  bht_spec #(.IWIDTH(IW), .HWIDTH(HW), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .en(en), .bus(bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [HW-1:0] m [N];
  logic [HW-1:0] exp_q [$];
  logic [HW-1:0] sb_exp;

  // Scoreboard: every accepted predict must report the expected prior history.
  always @(negedge clk) begin
    if (!reset && en && bus.pred_valid && bus.pred_ready) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected_pred idx=%0d got accept expected none", bus.pred_index);
      end else begin
        sb_exp = exp_q.pop_front();
        if (bus.pred_hist !== sb_exp)
          $display("FAIL sb_pred_hist idx=%0d got=%b exp=%b", bus.pred_index, bus.pred_hist, sb_exp);
        else pass_cnt++;
      end
    end
  end

  task automatic drv(input logic pv, input logic [IW-1:0] idx, input logic g,
                     input logic rv, input logic rt, input logic rm);
    bus.pred_valid = pv; bus.pred_index = idx; bus.pred_guess = g;
    bus.resolve_valid = rv; bus.resolve_taken = rt; bus.resolve_mispredict = rm;
  endtask

  task automatic expect_pred(input logic [IW-1:0] idx, input logic g);
    exp_q.push_back(m[idx]);
    m[idx] = {m[idx][HW-2:0], g};
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; drv(0, '0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    total_cnt++; if (bus.pred_ready !== 1'b1) $display("FAIL rst_pred_ready got=%b exp=1", bus.pred_ready); else pass_cnt++;
    total_cnt++; if (bus.resolve_ready !== 1'b0) $display("FAIL rst_resolve_ready got=%b exp=0", bus.resolve_ready); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.inflight !== 0) $display("FAIL rst_inflight got=%0d exp=0", bus.inflight); else pass_cnt++;
    for (int i = 0; i < N; i++) begin
      m[i] = '0;
      bus.pred_index = IW'(i); #1;
      total_cnt++; if (bus.pred_hist !== m[i]) $display("FAIL rst_hist idx=%0d got=%b exp=%b", i, bus.pred_hist, m[i]); else pass_cnt++;
    end
  endtask

  task automatic test_predict_correct();
    cyc(); drv(1, 3, 1, 0, 0, 0); expect_pred(3, 1);
    @(negedge clk);
    total_cnt++; if (bus.pred_hist !== 6'b000000) $display("FAIL pc_hist0 got=%b exp=000000", bus.pred_hist); else pass_cnt++;
    cyc(); drv(1, 3, 1, 0, 0, 0); expect_pred(3, 1);
    @(negedge clk);
    total_cnt++; if (bus.pred_hist !== 6'b000001) $display("FAIL pc_hist1 got=%b exp=000001", bus.pred_hist); else pass_cnt++;
    cyc(); drv(0, 3, 0, 0, 0, 0);
    @(negedge clk);
    total_cnt++; if (bus.pred_hist !== 6'b000011) $display("FAIL pc_hist2 got=%b exp=000011", bus.pred_hist); else pass_cnt++;
    total_cnt++; if (bus.inflight !== 2) $display("FAIL pc_inflight2 got=%0d exp=2", bus.inflight); else pass_cnt++;
    cyc(); drv(0, 3, 0, 1, 0, 0);
    @(negedge clk);
    total_cnt++; if (bus.resolve_ready !== 1'b1) $display("FAIL pc_resolve_ready got=%b exp=1", bus.resolve_ready); else pass_cnt++;
    cyc();
    @(negedge clk);
    total_cnt++; if (bus.inflight !== 1) $display("FAIL pc_inflight1 got=%0d exp=1", bus.inflight); else pass_cnt++;
    cyc(); drv(0, 3, 0, 0, 0, 0);
    @(negedge clk);
    total_cnt++; if (bus.inflight !== 0) $display("FAIL pc_inflight0 got=%0d exp=0", bus.inflight); else pass_cnt++;
    total_cnt++; if (bus.pred_hist !== 6'b000011) $display("FAIL pc_hist_kept got=%b exp=000011", bus.pred_hist); else pass_cnt++;
    total_cnt++; if (bus.resolve_ready !== 1'b0) $display("FAIL pc_resolve_idle got=%b exp=0", bus.resolve_ready); else pass_cnt++;
  endtask

  task automatic test_mispredict();
    int nbusy = 0;
    bit done = 0;
    cyc(); drv(1, 5, 0, 0, 0, 0); expect_pred(5, 0);
    cyc(); drv(1, 7, 1, 0, 0, 0); expect_pred(7, 1);
    cyc(); drv(1, 5, 1, 0, 0, 0); expect_pred(5, 1);
    cyc(); drv(1, 9, 1, 1, 1, 1);
    @(negedge clk);
    total_cnt++; if (bus.pred_ready !== 1'b0) $display("FAIL mp_pred_blocked got=%b exp=0", bus.pred_ready); else pass_cnt++;
    total_cnt++; if (bus.inflight !== 3) $display("FAIL mp_inflight3 got=%0d exp=3", bus.inflight); else pass_cnt++;
    cyc(); drv(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!bus.busy) begin done = 1; break; end
      nbusy++;
      total_cnt++; if (bus.pred_ready !== 1'b0) $display("FAIL mp_ready_in_repair got=%b exp=0", bus.pred_ready); else pass_cnt++;
    end
    total_cnt++; if (!done) $display("FAIL mp_timeout busy still high after 20 cycles"); else pass_cnt++;
    total_cnt++; if (nbusy !== 3) $display("FAIL mp_busy_cycles got=%0d exp=3", nbusy); else pass_cnt++;
    total_cnt++; if (bus.inflight !== 0) $display("FAIL mp_inflight0 got=%0d exp=0", bus.inflight); else pass_cnt++;
    m[5] = 6'b000001; m[7] = 6'b000000;
    for (int i = 0; i < N; i++) begin
      bus.pred_index = IW'(i); #1;
      total_cnt++; if (bus.pred_hist !== m[i]) $display("FAIL mp_hist idx=%0d got=%b exp=%b", i, bus.pred_hist, m[i]); else pass_cnt++;
    end
  endtask

  task automatic test_full_wrap();
    int nbusy = 0;
    bit done = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(); drv(1, IW'(10 + i), 1, 0, 0, 0); expect_pred(IW'(10 + i), 1);
    end
    cyc(); drv(1, 20, 1, 0, 0, 0);
    @(negedge clk);
    total_cnt++; if (bus.pred_ready !== 1'b0) $display("FAIL full_ready got=%b exp=0", bus.pred_ready); else pass_cnt++;
    total_cnt++; if (bus.inflight !== 8) $display("FAIL full_inflight got=%0d exp=8", bus.inflight); else pass_cnt++;
    cyc(); drv(1, 20, 1, 1, 0, 0);
    @(negedge clk);
    total_cnt++; if (bus.resolve_ready !== 1'b1) $display("FAIL full_resolve_ready got=%b exp=1", bus.resolve_ready); else pass_cnt++;
    cyc(); drv(0, 20, 0, 0, 0, 0);
    @(negedge clk);
    total_cnt++; if (bus.inflight !== 7) $display("FAIL full_pop_inflight got=%0d exp=7", bus.inflight); else pass_cnt++;
    total_cnt++; if (bus.pred_ready !== 1'b1) $display("FAIL full_ready_again got=%b exp=1", bus.pred_ready); else pass_cnt++;
    cyc(); drv(0, 0, 0, 1, 0, 0);
    repeat (3) cyc();
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    total_cnt++; if (bus.inflight !== 4) $display("FAIL wrap_inflight4 got=%0d exp=4", bus.inflight); else pass_cnt++;
    for (int j = 0; j < 4; j++) begin
      cyc(); drv(1, IW'(20 + j), 1, 1, 0, 0); expect_pred(IW'(20 + j), 1);
    end
    cyc(); drv(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    total_cnt++; if (bus.inflight !== 4) $display("FAIL wrap_simul_inflight got=%0d exp=4", bus.inflight); else pass_cnt++;
    cyc(); drv(0, 0, 0, 1, 1, 1);
    cyc(); drv(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!bus.busy) begin done = 1; break; end
      nbusy++;
    end
    total_cnt++; if (!done) $display("FAIL wrap_timeout busy still high after 20 cycles"); else pass_cnt++;
    total_cnt++; if (nbusy !== 4) $display("FAIL wrap_busy_cycles got=%0d exp=4", nbusy); else pass_cnt++;
    m[20] = 6'b000001; m[21] = '0; m[22] = '0; m[23] = '0;
    for (int i = 0; i < N; i++) begin
      bus.pred_index = IW'(i); #1;
      total_cnt++; if (bus.pred_hist !== m[i]) $display("FAIL wrap_hist idx=%0d got=%b exp=%b", i, bus.pred_hist, m[i]); else pass_cnt++;
    end
  endtask

  task automatic test_enable();
    int nbusy = 0;
    bit done = 0;
    cyc(); drv(1, 30, 1, 0, 0, 0); expect_pred(30, 1);
    cyc(); en = 1'b0; drv(1, 30, 1, 1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total_cnt++; if (bus.pred_hist !== 6'b000001) $display("FAIL en_hist k=%0d got=%b exp=000001", k, bus.pred_hist); else pass_cnt++;
      total_cnt++; if (bus.inflight !== 1) $display("FAIL en_inflight k=%0d got=%0d exp=1", k, bus.inflight); else pass_cnt++;
      total_cnt++; if (bus.pred_ready !== 1'b1 || bus.resolve_ready !== 1'b1 || bus.busy !== 1'b0)
        $display("FAIL en_ready k=%0d got=%b%b%b exp=110", k, bus.pred_ready, bus.resolve_ready, bus.busy); else pass_cnt++;
      cyc();
    end
    en = 1'b1; drv(1, 31, 1, 0, 0, 0); expect_pred(31, 1);
    cyc(); drv(0, 0, 0, 1, 0, 1);
    @(negedge clk);
    total_cnt++; if (bus.inflight !== 2) $display("FAIL en_inflight2 got=%0d exp=2", bus.inflight); else pass_cnt++;
    cyc(); drv(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!bus.busy) begin done = 1; break; end
      nbusy++;
      @(posedge clk); #1;
      en = (k == 0 || k == 1) ? 1'b0 : 1'b1;
    end
    en = 1'b1;
    total_cnt++; if (!done) $display("FAIL en_timeout busy still high after 20 cycles"); else pass_cnt++;
    total_cnt++; if (nbusy !== 4) $display("FAIL en_busy_stretch got=%0d exp=4", nbusy); else pass_cnt++;
    m[30] = '0; m[31] = '0;
    bus.pred_index = 30; #1;
    total_cnt++; if (bus.pred_hist !== m[30]) $display("FAIL en_hist30 got=%b exp=%b", bus.pred_hist, m[30]); else pass_cnt++;
    bus.pred_index = 31; #1;
    total_cnt++; if (bus.pred_hist !== m[31]) $display("FAIL en_hist31 got=%b exp=%b", bus.pred_hist, m[31]); else pass_cnt++;
  endtask

  task automatic test_reset_in_repair();
    for (int i = 0; i < 3; i++) begin
      cyc(); drv(1, IW'(40 + i), 1, 0, 0, 0); expect_pred(IW'(40 + i), 1);
    end
    cyc(); drv(0, 0, 0, 1, 1, 1);
    cyc(); drv(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    total_cnt++; if (bus.busy !== 1'b1) $display("FAIL rr_busy_c1 got=%b exp=1", bus.busy); else pass_cnt++;
    cyc(); reset = 1'b1;
    @(negedge clk);
    total_cnt++; if (bus.busy !== 1'b1) $display("FAIL rr_busy_c2 got=%b exp=1", bus.busy); else pass_cnt++;
    cyc(); reset = 1'b0;
    @(negedge clk);
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL rr_busy got=%b exp=0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.inflight !== 0) $display("FAIL rr_inflight got=%0d exp=0", bus.inflight); else pass_cnt++;
    total_cnt++; if (bus.pred_ready !== 1'b1 || bus.resolve_ready !== 1'b0)
      $display("FAIL rr_ready got=%b%b exp=10", bus.pred_ready, bus.resolve_ready); else pass_cnt++;
    for (int i = 0; i < N; i++) begin
      m[i] = '0;
      bus.pred_index = IW'(i); #1;
      total_cnt++; if (bus.pred_hist !== m[i]) $display("FAIL rr_hist idx=%0d got=%b exp=%b", i, bus.pred_hist, m[i]); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_predict_correct();
    test_mispredict();
    test_full_wrap();
    test_enable();
    test_reset_in_repair();
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
